// File: rtl/debug_pipeline_controller.sv
// Debug-unit sequencer for the five-stage MIPS pipeline: free-run, single-step,
// or freeze and stream the register bank word by word to the UART transmitter.
module debug_pipeline_controller #(
  parameter int len                  = 32,
  parameter int cantidad_registros   = 32,
  parameter int NB_address_registros = $clog2(cantidad_registros)
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_cmd_valid,
  input  logic [1:0]                      i_cmd,
  output logic                            o_cmd_ready,
  input  logic                            i_halt_detected,
  output logic                            o_pipe_enable,
  output logic                            o_halted,
  output logic                            o_dbg_reg_sel,
  output logic [NB_address_registros-1:0] o_dbg_reg_addr,
  input  logic [len-1:0]                  i_reg_data,
  output logic [len-1:0]                  o_tx_data,
  output logic                            o_tx_valid,
  input  logic                            i_tx_ready
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RUN       = 3'd1;
  localparam logic [2:0] STEP      = 3'd2;
  localparam logic [2:0] DUMP_ADDR = 3'd3;
  localparam logic [2:0] DUMP_SEND = 3'd4;

  localparam logic [1:0] CMD_RUN  = 2'b00;
  localparam logic [1:0] CMD_STEP = 2'b01;
  localparam logic [1:0] CMD_DUMP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  localparam logic [NB_address_registros-1:0] LAST_ADDR =
    NB_address_registros'(cantidad_registros - 1);

  logic [2:0]                      state_reg, state_next;
  logic [NB_address_registros-1:0] addr_reg, addr_next;
  logic                            pipe_en_reg;
  logic                            halted_reg;
  logic                            sel_reg;
  logic                            tx_valid_reg;
  logic [len-1:0]                  tx_data_reg;
  logic                            cmd_accept;
  logic                            tx_fire;

  assign o_cmd_ready = (state_reg == IDLE) || (state_reg == RUN);
  assign cmd_accept  = i_cmd_valid && o_cmd_ready;
  assign tx_fire     = tx_valid_reg && i_tx_ready;

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_accept) begin
          case (i_cmd)
            CMD_RUN:  if (!halted_reg) state_next = RUN;
            CMD_STEP: if (!halted_reg) state_next = STEP;
            CMD_DUMP: begin
              state_next = DUMP_ADDR;
              addr_next  = '0;
            end
            default:  state_next = IDLE;
          endcase
        end
      end
      RUN: begin
        // Other commands are swallowed here so the receiver never stalls.
        if (i_halt_detected || (cmd_accept && i_cmd == CMD_HALT))
          state_next = IDLE;
      end
      STEP:      state_next = IDLE;
      DUMP_ADDR: state_next = DUMP_SEND;
      DUMP_SEND: begin
        if (tx_fire) begin
          if (addr_reg == LAST_ADDR) begin
            state_next = IDLE;
            addr_next  = '0;
          end else begin
            state_next = DUMP_ADDR;
            addr_next  = addr_reg + 1'b1;
          end
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      pipe_en_reg  <= 1'b0;
      halted_reg   <= 1'b0;
      sel_reg      <= 1'b0;
      tx_valid_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      pipe_en_reg  <= (state_next == RUN) || (state_next == STEP);
      sel_reg      <= (state_next == DUMP_ADDR) || (state_next == DUMP_SEND);
      tx_valid_reg <= (state_next == DUMP_SEND);
      if (state_reg == DUMP_ADDR)
        tx_data_reg <= i_reg_data;
      if (i_halt_detected && pipe_en_reg)
        halted_reg <= 1'b1;
    end
  end

  assign o_pipe_enable  = pipe_en_reg;
  assign o_halted       = halted_reg;
  assign o_dbg_reg_sel  = sel_reg;
  assign o_dbg_reg_addr = addr_reg;
  assign o_tx_valid     = tx_valid_reg;
  assign o_tx_data      = tx_data_reg;

endmodule

// File: doc/debug_pipeline_controller.md
# debug_pipeline_controller

Sequences the five-stage MIPS pipeline for the debug unit: runs it continuously, single-steps it, or freezes it and dumps the register bank word by word to the UART transmitter. While dumping, it takes ownership of register-bank read port 1 from the instruction decode stage. It sits between the UART command receiver/transmitter and the pipeline stage-enable and register-bank address muxes.

## Interface
Parameters:
- len, 32, datapath / register width
- cantidad_registros, 32, number of registers in the bank
- NB_address_registros, $clog2(cantidad_registros), register address width

Ports:
- i_clk  in  1  single clock for the whole block
- i_rst  in  1  reset, synchronous and active-low
- i_cmd_valid  in  1  command strobe from the UART receiver
- i_cmd  in  2  command code: 00 RUN, 01 STEP, 10 DUMP, 11 HALT
- o_cmd_ready  out  1  command accepted on a cycle where i_cmd_valid && o_cmd_ready
- i_halt_detected  in  1  HALT instruction reached writeback
- o_pipe_enable  out  1  global enable for the IF/ID/EX/MEM/WB latches and PC
- o_halted  out  1  sticky flag: program finished
- o_dbg_reg_sel  out  1  1 = register-bank read port 1 driven by o_dbg_reg_addr instead of rs
- o_dbg_reg_addr  out  NB_address_registros  register address during a dump
- i_reg_data  in  len  read data 1 from the register bank
- o_tx_data  out  len  word to the UART transmitter
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  transmitter accepts the word

## Operation
- States: IDLE, RUN, STEP, DUMP_ADDR, DUMP_SEND.
- o_cmd_ready = 1 in IDLE and RUN, 0 otherwise (combinational from state).
- IDLE: o_pipe_enable = 0. Accepted RUN -> RUN; STEP -> STEP; DUMP -> DUMP_ADDR with address counter = 0. HALT is a no-op.
- If o_halted = 1, RUN and STEP are accepted but ignored (state stays IDLE). DUMP still works.
- RUN: o_pipe_enable = 1. Accepted HALT, or i_halt_detected = 1 -> IDLE. All other commands are accepted and discarded.
- STEP: o_pipe_enable = 1 for exactly one cycle, then IDLE unconditionally.
- o_halted is set when i_halt_detected = 1 and o_pipe_enable = 1. It is cleared only by reset. i_halt_detected is ignored while o_pipe_enable = 0.
- DUMP_ADDR: o_dbg_reg_sel = 1; o_dbg_reg_addr = counter; o_tx_valid = 0. The bank read settles this cycle. Next cycle -> DUMP_SEND, capturing i_reg_data into o_tx_data.
- DUMP_SEND: o_tx_valid = 1; o_tx_data is held stable until the handshake (o_tx_valid && i_tx_ready).
  - Handshake with counter < cantidad_registros-1: counter+1 -> DUMP_ADDR.
  - Handshake with counter = cantidad_registros-1: -> IDLE; counter returns to 0; o_dbg_reg_sel = 0.
  - The counter never wraps mid-dump.
- o_pipe_enable = 0 in both DUMP states, so pipeline contents are preserved across the dump.
- Simultaneous accepted HALT and i_halt_detected in RUN: a single transition to IDLE; o_halted = 1.

## Timing
- Reset values, all registered, visible the cycle after i_rst is sampled low:
  - state IDLE; o_pipe_enable 0; o_halted 0; o_dbg_reg_sel 0; o_dbg_reg_addr 0; o_tx_data 0; o_tx_valid 0.
  - o_cmd_ready is 1 whenever state is IDLE, including during reset.
- Command accepted at edge N -> new state and its outputs valid from cycle N+1.
- STEP: o_pipe_enable high for cycle N+1 only; o_cmd_ready back to 1 at N+2.
- RUN stop: i_halt_detected at edge M -> o_pipe_enable = 0 from cycle M+1.
- Dump with i_tx_ready tied to 1: 2 cycles per word, 2·cantidad_registros cycles total; IDLE on cycle N+1+2·cantidad_registros.
- Reset mid-dump: o_tx_valid drops the next cycle, no further words are sent, and o_dbg_reg_sel returns to 0.

## Test plan
- Reset, then RUN; i_halt_detected pulse 10 cycles later -> o_pipe_enable high exactly 10 cycles, o_halted = 1, o_cmd_ready = 1.
- Three STEP commands spaced 4 cycles apart -> exactly three single-cycle o_pipe_enable pulses, each one cycle after acceptance.
- Bank preloaded with reg[k] = 0x100+k, DUMP, i_tx_ready = 1 -> 32 words 0x100..0x11F in order; o_dbg_reg_sel high for 64 cycles; then IDLE.
- DUMP with i_tx_ready toggling 1-of-3 cycles -> o_tx_data stable while valid; no words lost or duplicated.
- After halt, issue RUN and STEP -> o_pipe_enable stays 0; DUMP still emits all 32 words.
- i_rst low during DUMP at word 5 -> next cycle o_tx_valid = 0, o_dbg_reg_sel = 0, o_halted = 0, state IDLE.
